// File: rtl/seg7_multi_ctrl_if.sv
// Avalon-MM register-bus bundle between the HPS lightweight bridge (master)
// and the seven-segment controller (slave).
interface seg7_multi_ctrl_if #(
  parameter int ADDR_W = 5
) ();
  logic [ADDR_W-1:0] avs_address;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic              avs_read;
  logic [31:0]       avs_readdata;

  modport master (
    output avs_address, avs_write, avs_writedata, avs_read,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_write, avs_writedata, avs_read,
    output avs_readdata
  );
endinterface

// File: rtl/seg7_multi_ctrl.sv
// Multi-digit seven-segment controller: per-digit hex/raw glyphs, blink mask
// with programmable period, global PWM brightness, registered conduit output.
module seg7_multi_ctrl #(
  parameter int NUM_DIGITS     = 6,
  parameter int ADDR_W         = 5,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter int BLINK_DIV      = 25000000
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  seg7_multi_ctrl_if.slave        avs,
  output logic [8*NUM_DIGITS-1:0] seg_export
);

  localparam int         BLINK_W  = $clog2(BLINK_DIV);
  localparam logic [7:0] OFF_BYTE = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

  logic                    enable_reg;
  logic [3:0]              bright_reg;
  logic [NUM_DIGITS-1:0]   mask_reg;
  logic [8:0]              digit_reg [NUM_DIGITS];
  logic [BLINK_W-1:0]      blink_cnt_reg;
  logic                    phase_reg;
  logic [3:0]              pwm_cnt_reg;
  logic [31:0]             readdata_reg;
  logic [31:0]             readdata_next;
  logic [8*NUM_DIGITS-1:0] seg_reg;
  logic [8*NUM_DIGITS-1:0] seg_next;
  logic                    ctrl_wr;
  logic                    blink_wr;
  logic                    pwm_on;
  logic                    unused_wdata;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  assign ctrl_wr      = avs.avs_write && (avs.avs_address == ADDR_W'(0));
  assign blink_wr     = avs.avs_write && (avs.avs_address == ADDR_W'(1));
  // Only the low bits of writedata land in registers; the rest are discarded.
  assign unused_wdata = ^avs.avs_writedata;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      enable_reg <= 1'b1;
      bright_reg <= 4'hF;
      mask_reg   <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) digit_reg[i] <= '0;
    end else begin
      if (ctrl_wr) begin
        enable_reg <= avs.avs_writedata[0];
        bright_reg <= avs.avs_writedata[7:4];
      end
      if (blink_wr) mask_reg <= avs.avs_writedata[NUM_DIGITS-1:0];
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (avs.avs_write && avs.avs_address == ADDR_W'(i + 2))
          digit_reg[i] <= avs.avs_writedata[8:0];
      end
    end
  end

  // Rewriting BLINK realigns the blink phase so software sees a clean start.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b0;
      pwm_cnt_reg   <= '0;
    end else begin
      pwm_cnt_reg <= pwm_cnt_reg + 4'd1;
      if (blink_wr) begin
        blink_cnt_reg <= '0;
        phase_reg     <= 1'b0;
      end else if (blink_cnt_reg == BLINK_W'(BLINK_DIV - 1)) begin
        blink_cnt_reg <= '0;
        phase_reg     <= ~phase_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + BLINK_W'(1);
      end
    end
  end

  always_comb begin
    readdata_next = '0;
    if (avs.avs_address == ADDR_W'(0)) begin
      readdata_next[0]   = enable_reg;
      readdata_next[7:4] = bright_reg;
    end else if (avs.avs_address == ADDR_W'(1)) begin
      readdata_next[NUM_DIGITS-1:0] = mask_reg;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (avs.avs_address == ADDR_W'(i + 2)) readdata_next[8:0] = digit_reg[i];
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) readdata_reg <= '0;
    else if (avs.avs_read) readdata_reg <= readdata_next;
  end

  assign avs.avs_readdata = readdata_reg;
  assign pwm_on           = (pwm_cnt_reg <= bright_reg);

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    logic [6:0] pattern;
    logic [7:0] glyph;
    logic       lit;

    assign pattern = digit_reg[gi][8] ? digit_reg[gi][6:0] : hex7(digit_reg[gi][3:0]);
    assign glyph   = {digit_reg[gi][7], pattern};
    assign lit     = enable_reg && pwm_on && !(mask_reg[gi] && phase_reg);
    assign seg_next[8*gi +: 8] = (lit ? glyph : 8'h00) ^ OFF_BYTE;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) seg_reg <= {NUM_DIGITS{OFF_BYTE}};
    else                seg_reg <= seg_next;
  end

  assign seg_export = seg_reg;

endmodule

// File: tb/tb_seg7_multi_ctrl.sv
// Bench for seg7_multi_ctrl: directed steps plus random register traffic,
// checked every cycle against a behavioural model of the display.
module tb_seg7_multi_ctrl;
  localparam int ND = 6;
  localparam int AW = 5;
  localparam int BD = 4;
  localparam logic [7:0] HEX_TAB [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                          8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [8*ND-1:0] seg;
  always #5 clk = ~clk;

  seg7_multi_ctrl_if #(.ADDR_W(AW)) bus ();

  seg7_multi_ctrl #(
    .NUM_DIGITS(ND), .ADDR_W(AW), .SEG_ACTIVE_LOW(1'b1), .BLINK_DIV(BD)
  ) dut (
    .clk_clk(clk),
    .reset_reset_n(rst_n),
    .avs(bus.slave),
    .seg_export(seg)
  );

  int checks = 0;
  int errors = 0;

  // Model: register contents plus elapsed edges since reset / last BLINK write.
  bit          m_en;
  bit [3:0]    m_br;
  bit [ND-1:0] m_mask;
  bit [8:0]    m_dig [ND];
  int          cyc;
  int          bk;
  logic [8*ND-1:0] exp_seg;
  logic [31:0]     exp_rd;

  function automatic logic [8*ND-1:0] model_out();
    logic [8*ND-1:0] r;
    logic [7:0] g;
    bit blank_phase;
    bit pwm_on;
    blank_phase = ((bk / BD) % 2) == 1;
    pwm_on = (cyc % 16) <= int'(m_br);
    r = '0;
    for (int i = 0; i < ND; i++) begin
      g = m_dig[i][8] ? {1'b0, m_dig[i][6:0]} : HEX_TAB[m_dig[i][3:0]];
      g[7] = m_dig[i][7];
      if (!(m_en && pwm_on && !(m_mask[i] && blank_phase))) g = 8'h00;
      r[8*i +: 8] = ~g;
    end
    return r;
  endfunction

  function automatic logic [31:0] model_rd(input int a);
    logic [31:0] r;
    r = '0;
    if (a == 0) begin
      r[0] = m_en;
      r[7:4] = m_br;
    end else if (a == 1) begin
      r[ND-1:0] = m_mask;
    end else if (a < ND + 2) begin
      r[8:0] = m_dig[a-2];
    end
    return r;
  endfunction

  task automatic model_write(input int a, input logic [31:0] d);
    if (a == 0) begin
      m_en = d[0];
      m_br = d[7:4];
    end else if (a == 1) begin
      m_mask = d[ND-1:0];
    end else if (a < ND + 2) begin
      m_dig[a-2] = d[8:0];
    end
  endtask

  task automatic model_reset();
    m_en = 1'b1;
    m_br = 4'hF;
    m_mask = '0;
    for (int i = 0; i < ND; i++) m_dig[i] = '0;
    cyc = 0;
    bk = 0;
  endtask

  task automatic check_seg(input string tag, input logic [8*ND-1:0] want);
    checks++;
    assert (seg === want) else begin
      errors++;
      $error("FAIL %s: seg_export=%h expected %h", tag, seg, want);
    end
  endtask

  task automatic check_rd(input string tag, input logic [31:0] want);
    checks++;
    assert (bus.avs_readdata === want) else begin
      errors++;
      $error("FAIL %s: readdata=%h expected %h", tag, bus.avs_readdata, want);
    end
  endtask

  // One bus cycle: drive, clock, advance model, compare both outputs.
  task automatic cycle(input bit wr, input bit rd, input int a, input logic [31:0] d);
    logic [8*ND-1:0] nxt;
    bus.avs_address   = a[AW-1:0];
    bus.avs_write     = wr;
    bus.avs_read      = rd;
    bus.avs_writedata = d;
    nxt = model_out();
    if (rd) exp_rd = model_rd(a);
    @(posedge clk);
    #1;
    cyc++;
    bk = (wr && a == 1) ? 0 : bk + 1;
    if (wr) model_write(a, d);
    exp_seg = nxt;
    bus.avs_write = 1'b0;
    bus.avs_read  = 1'b0;
    $display("cyc=%0d wr=%0b rd=%0b addr=%0d wdata=%h seg=%h rdata=%h",
             cyc, wr, rd, a, d, seg, bus.avs_readdata);
    check_seg("seg_model", exp_seg);
    check_rd("rd_model", exp_rd);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    exp_seg = '1;
    exp_rd  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_seg("reset_seg", {(8*ND){1'b1}});
    check_rd("reset_rd", 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0, 0, 0, 0);
    check_seg("release_seg", {ND{8'hC0}});
  endtask

  initial begin
    int lit_cnt;
    int op;
    int a;
    logic [31:0] d;
    bus.avs_address = '0;
    bus.avs_write = 1'b0;
    bus.avs_read = 1'b0;
    bus.avs_writedata = '0;
    model_reset();

    do_reset();
    cycle(0, 0, 0, 0);
    check_seg("steady_after_reset", {ND{8'hC0}});

    // Hex decode with dp, then readback.
    cycle(1, 0, 2, 32'h0000_008A);
    cycle(0, 0, 0, 0);
    check_seg("digit0_hexA_dp", {{(ND-1){8'hC0}}, 8'h08});
    cycle(0, 1, 2, 0);
    check_rd("read_digit0", 32'h0000_008A);

    // Raw mode bypasses the decoder.
    cycle(1, 0, 3, 32'h0000_015A);
    cycle(0, 0, 0, 0);
    check_seg("digit1_raw", {{(ND-2){8'hC0}}, 8'hA5, 8'h08});

    // Blink digit 0.
    cycle(1, 0, 1, 32'h0000_0001);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0);

    // PWM at BRIGHT=3: digit 0 lit 4 of any 16 consecutive cycles.
    cycle(1, 0, 1, 32'h0);
    cycle(1, 0, 0, 32'h0000_0031);
    cycle(0, 0, 0, 0);
    lit_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(0, 0, 0, 0);
      if (seg[7:0] != 8'hFF) lit_cnt++;
    end
    checks++;
    assert (lit_cnt == 4) else begin
      errors++;
      $error("FAIL pwm_duty: lit cycles=%0d expected 4", lit_cnt);
    end

    // Disable: everything blank; CTRL reads back.
    cycle(1, 0, 0, 32'h0000_0030);
    cycle(0, 0, 0, 0);
    check_seg("disabled_blank", {(8*ND){1'b1}});
    cycle(0, 1, 0, 0);
    check_rd("read_ctrl", 32'h0000_0030);
    cycle(1, 0, 0, 32'h0000_00F1);

    // Out-of-range address and same-cycle read/write.
    cycle(1, 0, 31, 32'hFFFF_FFFF);
    cycle(0, 1, 31, 0);
    check_rd("read_addr31", 32'h0);
    cycle(1, 0, 4, 32'h0000_0107);
    cycle(1, 1, 4, 32'h0000_0003);
    check_rd("rw_same_cycle_old", 32'h0000_0107);
    cycle(0, 1, 4, 0);
    check_rd("rw_then_new", 32'h0000_0003);

    // Random register traffic.
    for (int n = 0; n < 400; n++) begin
      op = int'($urandom_range(0, 3));
      a  = ($urandom_range(0, 15) == 0) ? 31 : int'($urandom_range(0, ND + 3));
      d  = $urandom;
      if (a == 0 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
      cycle(op[0], op[1], a, d);
    end

    // Reset in the middle of blinking / PWM restarts the counters.
    cycle(1, 0, 1, 32'h0000_003F);
    cycle(1, 0, 0, 32'h0000_0071);
    repeat (5) cycle(0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
